// File: rtl/bsc_scan_ctrl.sv
// Boundary-scan capture/shift/update controller for an L = NCELL*NBIT cell chain.
// Optional expected-data compare is built only when BSC_CMP_EN is defined.
`timescale 1ns/1ps
module bsc_scan_ctrl #(
  parameter int NCELL = 4,
  parameter int NBIT  = 3
) (
  input  logic                  tck,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NCELL*NBIT-1:0] wdata,
  input  logic                  scan_tdo,
`ifdef BSC_CMP_EN
  input  logic [NCELL*NBIT-1:0] exp_data,
  input  logic [NCELL*NBIT-1:0] exp_mask,
  output logic                  mismatch,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [NCELL*NBIT-1:0] rdata,
  output logic                  scan_cdr,
  output logic                  scan_sdr,
  output logic                  scan_udr,
  output logic                  scan_tdi
);

  localparam int L  = NCELL * NBIT;
  localparam int CW = (L > 1) ? $clog2(L) : 1;

  typedef enum logic [2:0] {
    IDLE, CAPTURE, SHIFT, EXIT, UPDATE, DONE
  } state_t;

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic [L-1:0]   sr_q;
  logic [L-1:0]   cap_q;
  logic [L-1:0]   cap_d;
  logic [L-1:0]   rdata_q;
  logic           busy_q;
  logic           done_q;
  logic           cdr_q;
  logic           sdr_q;
  logic           udr_q;
  logic           tdi_q;
`ifdef BSC_CMP_EN
  logic           mism_q;
`endif

  // Chain bits return LSB first, so each sample enters at the top and moves down.
  always_comb begin
    cap_d        = cap_q >> 1;
    cap_d[L-1]   = scan_tdo;
  end

  // Scan sequencer with registered strobes, serial data and result word.
  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      cap_q   <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cdr_q   <= 1'b0;
      sdr_q   <= 1'b0;
      udr_q   <= 1'b0;
      tdi_q   <= 1'b0;
`ifdef BSC_CMP_EN
      mism_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (busy_q && abort) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
        cdr_q   <= 1'b0;
        sdr_q   <= 1'b0;
        udr_q   <= 1'b0;
        tdi_q   <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (start && !abort) begin
              state_q <= CAPTURE;
              sr_q    <= wdata;
              busy_q  <= 1'b1;
              cdr_q   <= 1'b1;
            end
          end
          CAPTURE: begin
            state_q <= SHIFT;
            cnt_q   <= '0;
            cdr_q   <= 1'b0;
            sdr_q   <= 1'b1;
            tdi_q   <= sr_q[0];
            sr_q    <= sr_q >> 1;
          end
          SHIFT: begin
            cap_q <= cap_d;
            if (cnt_q == CW'(L - 1)) begin
              state_q <= EXIT;
              sdr_q   <= 1'b0;
              tdi_q   <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
              tdi_q <= sr_q[0];
              sr_q  <= sr_q >> 1;
            end
          end
          EXIT: begin
            state_q <= UPDATE;
            udr_q   <= 1'b1;
          end
          UPDATE: begin
            state_q <= DONE;
            udr_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            rdata_q <= cap_q;
`ifdef BSC_CMP_EN
            mism_q  <= |((cap_q ^ exp_data) & exp_mask);
`endif
          end
          DONE: begin
            state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cdr_q   <= 1'b0;
            sdr_q   <= 1'b0;
            udr_q   <= 1'b0;
            tdi_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rdata    = rdata_q;
  assign scan_cdr = cdr_q;
  assign scan_sdr = sdr_q;
  assign scan_udr = udr_q;
  assign scan_tdi = tdi_q;
`ifdef BSC_CMP_EN
  assign mismatch = mism_q;
`endif

endmodule

// File: tb/tb_bsc_scan_ctrl.sv
// Scoreboard bench for bsc_scan_ctrl with a serial chain model.
// Compare checks run when compiled with BSC_CMP_EN.
`timescale 1ns/1ps
module tb_bsc_scan_ctrl;
  localparam int L = 12;

  logic         tck = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [L-1:0] wdata = '0;
  logic         scan_tdo;
  logic         busy, done, scan_cdr, scan_sdr, scan_udr, scan_tdi;
  logic [L-1:0] rdata;
`ifdef BSC_CMP_EN
  logic [L-1:0] exp_data = '0;
  logic [L-1:0] exp_mask = '0;
  logic         mismatch;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int nexp = 0;
  int cdr_c = -1;
  int udr_c = -1;
  int udr_n = 0;
  int done_n = 0;

  typedef struct {
    logic [L-1:0] w;
    logic [L-1:0] r;
    int           e;
    logic         mm;
  } exp_t;
  exp_t q[$];
  exp_t mx;

  logic [L-1:0] ret = '0;
  logic [L-1:0] chain;
  logic [L-1:0] tdi_word = '0;
  logic [L-1:0] last_rdata = '0;

  bsc_scan_ctrl #(.NCELL(4), .NBIT(3)) dut (
    .tck(tck), .rst_n(rst_n), .start(start), .abort(abort),
    .wdata(wdata), .scan_tdo(scan_tdo),
`ifdef BSC_CMP_EN
    .exp_data(exp_data), .exp_mask(exp_mask), .mismatch(mismatch),
`endif
    .busy(busy), .done(done), .rdata(rdata),
    .scan_cdr(scan_cdr), .scan_sdr(scan_sdr),
    .scan_udr(scan_udr), .scan_tdi(scan_tdi)
  );

  always #5 tck = ~tck;
  always @(posedge tck) cyc <= cyc + 1;

  always @(posedge tck or negedge rst_n)
    if (!rst_n) chain <= '0;
    else if (scan_cdr) chain <= ret;
    else if (scan_sdr) chain <= {scan_tdi, chain[L-1:1]};
  assign scan_tdo = chain[0];

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] x);
    checks++;
    if (a !== x) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h cyc=%0d", n, a, x, cyc);
    end
  endtask

  always @(negedge tck) begin
    if (rst_n) begin
      chk("strobe_excl",
          32'(scan_cdr) + 32'(scan_sdr) + 32'(scan_udr) <= 32'd1, 1);
      if (!scan_sdr) chk("tdi_quiet", scan_tdi, 0);
      if (scan_cdr) cdr_c = cyc;
      if (scan_udr) begin
        udr_c = cyc;
        udr_n++;
        tdi_word = chain;
      end
      if (done) begin
        done_n++;
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_done actual=1 required=0 cyc=%0d", cyc);
        end else begin
          mx = q.pop_front();
          chk("rdata", rdata, mx.r);
          chk("tdi_seq", tdi_word, mx.w);
          chk("cdr_cycle", cdr_c, mx.e);
          chk("udr_cycle", udr_c, mx.e + L + 2);
          chk("done_cycle", cyc, mx.e + L + 3);
          chk("busy_in_done", busy, 0);
`ifdef BSC_CMP_EN
          chk("mismatch", mismatch, mx.mm);
`endif
          last_rdata = mx.r;
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge tck);
    while ((busy || done) && n < 100) begin
      @(negedge tck);
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout actual=busy required=idle");
    end
  endtask

  task automatic wait_cyc(input int t);
    int n = 0;
    while (cyc != t && n < 200) begin
      @(negedge tck);
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL cyc_timeout actual=%0d required=%0d", cyc, t);
    end
  endtask

  task automatic issue(input logic [L-1:0] w, input logic [L-1:0] r,
                       input logic [L-1:0] ed, input logic [L-1:0] em,
                       input logic mm, input bit push, output int e);
    wait_idle();
    wdata = w;
    ret = r;
`ifdef BSC_CMP_EN
    exp_data = ed;
    exp_mask = em;
`endif
    start = 1'b1;
    e = cyc + 1;
    if (push) begin
      q.push_back('{w, r, e, mm});
      nexp++;
    end
    @(negedge tck);
    start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge tck);
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d required=0", q.size());
    end
    repeat (2) @(negedge tck);
  endtask

  task automatic chk_all_zero(input string n);
    chk({n, "_busy"}, busy, 0);
    chk({n, "_done"}, done, 0);
    chk({n, "_cdr"}, scan_cdr, 0);
    chk({n, "_sdr"}, scan_sdr, 0);
    chk({n, "_udr"}, scan_udr, 0);
    chk({n, "_tdi"}, scan_tdi, 0);
    chk({n, "_rdata"}, rdata, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    int e2;
    #1;
    chk_all_zero("reset");
    repeat (3) @(negedge tck);
    rst_n = 1'b1;

    issue(12'hA5C, 12'h3F0, '0, '0, 1'b0, 1'b1, e);
    drain();
    issue(12'h123, 12'hFED, '0, '0, 1'b0, 1'b1, e);
    drain();

    issue(12'h5A3, 12'h0F0, '0, '0, 1'b0, 1'b1, e);
    wait_cyc(e + 5);
    start = 1'b1;
    @(negedge tck);
    start = 1'b0;
    drain();
    repeat (20) @(negedge tck);
    chk("start_ignored_dones", done_n, nexp);

    issue(12'hFFF, 12'hABC, '0, '0, 1'b0, 1'b0, e);
    wait_cyc(e + 6);
    abort = 1'b1;
    @(negedge tck);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_sdr", scan_sdr, 0);
    repeat (25) @(negedge tck);
    chk("abort_rdata", rdata, last_rdata);
    chk("abort_udr", udr_n, nexp);
    chk("abort_done", done_n, nexp);

    issue(12'h0F0, 12'h555, '0, '0, 1'b0, 1'b0, e);
    wait_cyc(e + 8);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    last_rdata = '0;
    repeat (2) @(negedge tck);
    rst_n = 1'b1;
    repeat (20) @(negedge tck);
    chk("midreset_busy", busy, 0);
    chk("midreset_udr", udr_n, nexp);
    chk("midreset_done", done_n, nexp);

    issue(12'h321, 12'h111, '0, '0, 1'b0, 1'b0, e);
    abort = 1'b1;
    @(negedge tck);
    abort = 1'b0;
    chk("abort_capture", busy, 0);

    wait_idle();
    wdata = 12'h9C3;
    ret = 12'h246;
    start = 1'b1;
    abort = 1'b1;
    @(negedge tck);
    abort = 1'b0;
    start = 1'b0;
    chk("abort_wins", busy, 0);

    wait_idle();
    wdata = 12'h9C3;
    ret = 12'h246;
    start = 1'b1;
    e = cyc + 1;
    e2 = e + L + 5;
    q.push_back('{12'h9C3, 12'h246, e, 1'b0});
    q.push_back('{12'h6B1, 12'hC0D, e2, 1'b0});
    nexp += 2;
    wait_cyc(e + 1);
    wdata = 12'h6B1;
    ret = 12'hC0D;
    wait_cyc(e2);
    start = 1'b0;
    drain();

`ifdef BSC_CMP_EN
    issue(12'hA5C, 12'h3F0, 12'h3F0, 12'hFFF, 1'b0, 1'b1, e);
    drain();
    issue(12'hA5C, 12'h3F0, 12'h3F1, 12'hFFF, 1'b1, 1'b1, e);
    drain();
    issue(12'hA5C, 12'h3F0, 12'h3F1, 12'hFFE, 1'b0, 1'b1, e);
    drain();
`endif

    repeat (5) @(negedge tck);
    chk("final_rdata_hold", rdata, last_rdata);
    chk("total_done", done_n, nexp);
    chk("total_udr", udr_n, nexp);
    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
